// File: rtl/mdu_hilo_if.sv
// mdu_hilo_if: EX-stage bus between the core and the multiply/divide unit.
//   start     - MDU instruction valid this cycle (driven by EX)
//   mdu_op    - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved
//   A, B      - rs / rt operands
//   HI, LO    - architectural HI/LO registers (read by mfhi/mflo)
//   busy      - registered, an operation is in flight
//   hilo_busy - combinational busy seen by the stall logic
// master: EX stage side.  slave: the MDU.
interface mdu_hilo_if;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;
  logic        hilo_busy;

  modport master (
    output start, mdu_op, A, B,
    input  HI, LO, busy, hilo_busy
  );

  modport slave (
    input  start, mdu_op, A, B,
    output HI, LO, busy, hilo_busy
  );
endinterface

// File: rtl/mdu_hilo.sv
// mdu_hilo: multiply/divide unit holding the MIPS HI/LO registers.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-low reset
//   bus   - mdu_hilo_if.slave (start, mdu_op, A, B in; HI, LO, busy, hilo_busy out)
// mult/multu/div/divu latch their operands and hold busy for a fixed
// number of cycles; HI/LO are written on the edge where the countdown
// reaches zero. mthi/mtlo write in a single cycle. Requests made while
// busy are ignored.
module mdu_hilo #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  mdu_hilo_if.slave  bus
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Multiplier on the latched operands.
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // One unsigned divider serves both div and divu: signed division works on
  // magnitudes and fixes the signs afterwards. The magnitude of 0x80000000 is
  // 0x80000000 as an unsigned value, so the overflow case needs no special path.
  logic        div_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] dvd_mag;
  logic [31:0] dvs_mag;
  logic [31:0] quo_mag;
  logic [31:0] rem_mag;
  logic [31:0] quo;
  logic [31:0] rem;

  assign div_signed = (op_q == OP_DIV);
  assign a_neg      = div_signed & a_q[31];
  assign b_neg      = div_signed & b_q[31];
  assign dvd_mag    = a_neg ? (32'd0 - a_q) : a_q;
  assign dvs_mag    = b_neg ? (32'd0 - b_q) : b_q;
  assign quo_mag    = (dvs_mag == 32'd0) ? 32'd0 : (dvd_mag / dvs_mag);
  assign rem_mag    = (dvs_mag == 32'd0) ? 32'd0 : (dvd_mag % dvs_mag);
  // Quotient truncates toward zero; remainder follows the dividend's sign.
  assign quo        = (a_neg ^ b_neg) ? (32'd0 - quo_mag) : quo_mag;
  assign rem        = a_neg ? (32'd0 - rem_mag) : rem_mag;

  logic start_arith;
  assign start_arith = bus.start &&
                       ((bus.mdu_op == OP_MULT) || (bus.mdu_op == OP_MULTU) ||
                        (bus.mdu_op == OP_DIV)  || (bus.mdu_op == OP_DIVU));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          case (bus.mdu_op)
            OP_MULT, OP_MULTU: begin
              op_d    = bus.mdu_op;
              a_d     = bus.A;
              b_d     = bus.B;
              count_d = CW'(MULT_CYCLES);
              state_d = ST_RUN;
            end
            OP_DIV, OP_DIVU: begin
              op_d    = bus.mdu_op;
              a_d     = bus.A;
              b_d     = bus.B;
              count_d = CW'(DIV_CYCLES);
              state_d = ST_RUN;
            end
            OP_MTHI: hi_d = bus.A;
            OP_MTLO: lo_d = bus.A;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = ST_IDLE;
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_DIV, OP_DIVU: begin
              // Divide by zero completes on time but leaves HI/LO alone.
              if (b_q != 32'd0) begin
                lo_d = quo;
                hi_d = rem;
              end
            end
            default: ;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      op_q    <= OP_NONE;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.HI        = hi_q;
  assign bus.LO        = lo_q;
  assign bus.busy      = (count_q != '0);
  assign bus.hilo_busy = bus.busy | start_arith;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: randomized and directed checks of mdu_hilo against a
// 64-bit arithmetic reference model of HI/LO.
module tb_mdu_hilo;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu_hilo_if bus ();

  mdu_hilo #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: new HI/LO from op and operands, using wide signed arithmetic.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd1: begin sq = sa * sb; m_hi = sq[63:32]; m_lo = sq[31:0]; end
      3'd2: begin up = longint'(a) * longint'(b); m_hi = up[63:32]; m_lo = up[31:0]; end
      3'd3: if (b != 0) begin sq = sa / sb; sr = sa % sb; m_lo = sq[31:0]; m_hi = sr[31:0]; end
      3'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: ;
    endcase
  endtask

  function automatic int lat(input logic [2:0] op);
    if (op == 3'd1 || op == 3'd2) return MC;
    if (op == 3'd3 || op == 3'd4) return DC;
    return 0;
  endfunction

  // Drives one request at a negedge and runs until the first idle cycle.
  // Reports busy length, whether HI/LO held still while busy, and hilo_busy
  // in the request cycle. Live A/B are scrambled after acceptance.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int bcyc, output bit held, output logic hb0);
    logic [31:0] hi0, lo0;
    @(negedge clk);
    hi0 = bus.HI;
    lo0 = bus.LO;
    bus.start = 1'b1; bus.mdu_op = op; bus.A = a; bus.B = b;
    #1 hb0 = bus.hilo_busy;
    @(negedge clk);
    bus.start = 1'b0; bus.mdu_op = 3'd0; bus.A = $urandom; bus.B = $urandom;
    bcyc = 0;
    held = 1'b1;
    while (bus.busy === 1'b1 && bcyc < 60) begin
      if (bus.HI !== hi0 || bus.LO !== lo0) held = 1'b0;
      bcyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.start = 1'b1; bus.mdu_op = 3'd1; bus.A = 32'h5; bus.B = 32'h7;
    repeat (3) @(negedge clk);
    bus.start = 1'b0; bus.mdu_op = 3'd0;
    #1;
    total++;
    if (bus.HI !== 32'd0 || bus.LO !== 32'd0 || bus.busy !== 1'b0 || bus.hilo_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset: HI=%h LO=%h busy=%b hilo_busy=%b want 0/0/0/0",
               bus.HI, bus.LO, bus.busy, bus.hilo_busy);
    end
    reset = 1'b1;
    m_hi = 0; m_lo = 0;
    $display("reset checked");
  endtask

  // One op with full checks of latency, hold, start-cycle hilo_busy and result.
  task automatic test_op(input string name, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    int bc; bit held; logic hb0;
    run_op(op, a, b, bc, held, hb0);
    model(op, a, b);
    total++;
    if (bc != lat(op)) begin
      bad++; $display("FAIL %s latency: got %0d want %0d", name, bc, lat(op));
    end
    total++;
    if (!held) begin
      bad++; $display("FAIL %s hold: HI/LO changed while busy (got 0 want 1)", name);
    end
    total++;
    if (hb0 !== (lat(op) != 0)) begin
      bad++; $display("FAIL %s hilo_busy_start: got %b want %b", name, hb0, lat(op) != 0);
    end
    total++;
    if (bus.HI !== m_hi || bus.LO !== m_lo || bus.busy !== 1'b0) begin
      bad++; $display("FAIL %s result: HI=%h LO=%h busy=%b want HI=%h LO=%h busy=0",
                      name, bus.HI, bus.LO, bus.busy, m_hi, m_lo);
    end
    $display("op %s a=%h b=%h -> HI=%h LO=%h busy_cycles=%0d", name, a, b, bus.HI, bus.LO, bc);
  endtask

  task automatic test_directed;
    test_op("mult", 3'd1, 32'hFFFFFFFE, 32'd3);
    total++;
    if (m_hi !== 32'hFFFFFFFF || bus.LO !== 32'hFFFFFFFA) begin
      bad++; $display("FAIL mult_const: HI=%h LO=%h want ffffffff fffffffa", bus.HI, bus.LO);
    end
    test_op("multu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    total++;
    if (bus.HI !== 32'hFFFFFFFE || bus.LO !== 32'h00000001) begin
      bad++; $display("FAIL multu_const: HI=%h LO=%h want fffffffe 00000001", bus.HI, bus.LO);
    end
    test_op("div", 3'd3, 32'hFFFFFFF9, 32'd2);
    total++;
    if (bus.HI !== 32'hFFFFFFFF || bus.LO !== 32'hFFFFFFFD) begin
      bad++; $display("FAIL div_const: HI=%h LO=%h want ffffffff fffffffd", bus.HI, bus.LO);
    end
    test_op("divu", 3'd4, 32'hFFFFFFF9, 32'd2);
    total++;
    if (bus.HI !== 32'd1 || bus.LO !== 32'h7FFFFFFC) begin
      bad++; $display("FAIL divu_const: HI=%h LO=%h want 00000001 7ffffffc", bus.HI, bus.LO);
    end
    test_op("mthi", 3'd5, 32'h12345678, 32'd0);
    test_op("div0", 3'd3, 32'h00001234, 32'd0);
    test_op("divu0", 3'd4, 32'hFFFF0000, 32'd0);
    test_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF);
    total++;
    if (bus.HI !== 32'd0 || bus.LO !== 32'h80000000) begin
      bad++; $display("FAIL div_ovf_const: HI=%h LO=%h want 00000000 80000000", bus.HI, bus.LO);
    end
    test_op("none", 3'd0, 32'hAAAA5555, 32'd1);
    test_op("rsvd", 3'd7, 32'h5555AAAA, 32'd1);
  endtask

  task automatic test_ignore_while_busy;
    int bc;
    @(negedge clk);
    bus.start = 1'b1; bus.mdu_op = 3'd1; bus.A = 32'h00010003; bus.B = 32'hFFFFFFF0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.mdu_op = 3'd6; bus.A = 32'h0000DEAD; bus.B = 32'h0000BEEF;
    @(negedge clk);
    bus.start = 1'b1; bus.mdu_op = 3'd3; bus.A = 32'h77; bus.B = 32'h3;
    @(negedge clk);
    bus.start = 1'b0; bus.mdu_op = 3'd0; bus.A = $urandom; bus.B = $urandom;
    bc = 0;
    while (bus.busy === 1'b1 && bc < 60) begin bc++; @(negedge clk); end
    model(3'd1, 32'h00010003, 32'hFFFFFFF0);
    total++;
    if (bc != MC - 3) begin
      bad++; $display("FAIL ignore latency: got %0d remaining want %0d", bc, MC - 3);
    end
    total++;
    if (bus.HI !== m_hi || bus.LO !== m_lo) begin
      bad++; $display("FAIL ignore result: HI=%h LO=%h want HI=%h LO=%h", bus.HI, bus.LO, m_hi, m_lo);
    end
    $display("ignore-while-busy: HI=%h LO=%h", bus.HI, bus.LO);
  endtask

  task automatic test_reset_mid_run;
    bit late;
    @(negedge clk);
    bus.start = 1'b1; bus.mdu_op = 3'd4; bus.A = 32'd100; bus.B = 32'd7;
    @(negedge clk);
    bus.start = 1'b0; bus.mdu_op = 3'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_hi = 0; m_lo = 0;
    total++;
    if (bus.busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
      bad++; $display("FAIL reset_mid: busy=%b HI=%h LO=%h want 0/0/0", bus.busy, bus.HI, bus.LO);
    end
    late = 1'b0;
    repeat (DC + 2) begin
      @(negedge clk);
      if (bus.HI !== 32'd0 || bus.LO !== 32'd0 || bus.busy !== 1'b0) late = 1'b1;
    end
    total++;
    if (late) begin
      bad++; $display("FAIL reset_late_write: HI=%h LO=%h busy=%b want 0/0/0", bus.HI, bus.LO, bus.busy);
    end
    $display("reset mid-run: HI=%h LO=%h busy=%b", bus.HI, bus.LO, bus.busy);
  endtask

  task automatic test_back_to_back;
    int bc1, bc2;
    logic hb;
    logic [31:0] a2, b2;
    a2 = $urandom; b2 = $urandom;
    @(negedge clk);
    bus.start = 1'b1; bus.mdu_op = 3'd1; bus.A = 32'h7FFFFFFF; bus.B = 32'h7FFFFFFF;
    @(negedge clk);
    bus.start = 1'b0; bus.mdu_op = 3'd0;
    bc1 = 0;
    while (bus.busy === 1'b1 && bc1 < 60) begin bc1++; @(negedge clk); end
    model(3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF);
    total++;
    if (bc1 != MC || bus.HI !== m_hi || bus.LO !== m_lo) begin
      bad++; $display("FAIL b2b first: cycles=%0d HI=%h LO=%h want %0d HI=%h LO=%h",
                      bc1, bus.HI, bus.LO, MC, m_hi, m_lo);
    end
    // Same cycle busy first reads 0: present the next op immediately.
    bus.start = 1'b1; bus.mdu_op = 3'd2; bus.A = a2; bus.B = b2;
    #1 hb = bus.hilo_busy;
    total++;
    if (hb !== 1'b1) begin
      bad++; $display("FAIL b2b hilo_busy gap: got %b want 1", hb);
    end
    @(negedge clk);
    bus.start = 1'b0; bus.mdu_op = 3'd0;
    bc2 = 0;
    while (bus.busy === 1'b1 && bc2 < 60) begin bc2++; @(negedge clk); end
    model(3'd2, a2, b2);
    total++;
    if (bc2 != MC || bus.HI !== m_hi || bus.LO !== m_lo) begin
      bad++; $display("FAIL b2b second: cycles=%0d HI=%h LO=%h want %0d HI=%h LO=%h",
                      bc2, bus.HI, bus.LO, MC, m_hi, m_lo);
    end
    $display("back-to-back: multu a=%h b=%h -> HI=%h LO=%h", a2, b2, bus.HI, bus.LO);
  endtask

  task automatic test_random;
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = b & 32'h0000000F;
      test_op("rand", op, a, b);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.start = 1'b0; bus.mdu_op = 3'd0; bus.A = 32'd0; bus.B = 32'd0;
    m_hi = 0; m_lo = 0;
    test_reset;
    test_directed;
    test_ignore_while_busy;
    test_reset_mid_run;
    test_back_to_back;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past 200000 time units");
    $fatal(1, "timeout");
  end
endmodule
